hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait stalls, redirect flushes and load-use bubbles.
// Optional access timeout is enabled by defining HAZARD_CTRL_TIMEOUT_EN.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr_D,
    input  logic [4:0]  rs2_addr_D,
    input  logic [4:0]  rd_waddr_EX,
    input  logic        MemRead_EX,
    input  logic        redirect_EX,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        stall_PC,
    output logic        stall_F_D,
    output logic        stall_D_EX,
    output logic        stall_EX_M,
    output logic        flush_F_D,
    output logic        flush_D_EX,
    output logic        flush_M_WB,
    output logic [15:0] stall_cycles,
    output logic        mem_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   mem_op;
    logic   load_use;
    logic   mem_stall;

    assign mem_op   = MemRead_M | MemWrite_M;
    assign load_use = MemRead_EX && (rd_waddr_EX != 5'd0) &&
                      ((rd_waddr_EX == rs1_addr_D) || (rd_waddr_EX == rs2_addr_D));

`ifdef HAZARD_CTRL_TIMEOUT_EN
    logic [3:0] tmo_cnt;

    // Counts WAIT_MEM cycles; zero on the first cycle after entry.
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= 4'd0;
        else if (state == IDLE)
            tmo_cnt <= 4'd0;
        else
            tmo_cnt <= tmo_cnt + 4'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_stall  = 1'b0;
        dmem_req   = 1'b0;
        mem_err    = 1'b0;
        stall_PC   = 1'b0;
        stall_F_D  = 1'b0;
        stall_D_EX = 1'b0;
        stall_EX_M = 1'b0;
        flush_F_D  = 1'b0;
        flush_D_EX = 1'b0;
        flush_M_WB = 1'b0;

        case (state)
            IDLE: begin
                dmem_req = mem_op;
                if (mem_op && !dmem_ack) begin
                    mem_stall = 1'b1;
                    state_nxt = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_nxt = IDLE;
                end else begin
`ifdef HAZARD_CTRL_TIMEOUT_EN
                    if (tmo_cnt == 4'hF) begin
                        // Give up: drop the request and bubble the stuck M-stage op.
                        dmem_req   = 1'b0;
                        mem_err    = 1'b1;
                        flush_M_WB = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        mem_stall = 1'b1;
                    end
`else
                    mem_stall = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Memory stall dominates; redirect and load-use are only seen once it releases.
        if (mem_stall) begin
            stall_PC   = 1'b1;
            stall_F_D  = 1'b1;
            stall_D_EX = 1'b1;
            stall_EX_M = 1'b1;
            flush_M_WB = 1'b1;
        end else if (redirect_EX) begin
            flush_F_D  = 1'b1;
            flush_D_EX = 1'b1;
        end else if (load_use) begin
            stall_PC   = 1'b1;
            stall_F_D  = 1'b1;
            flush_D_EX = 1'b1;
        end

        if (rst) begin
            state_nxt  = IDLE;
            dmem_req   = 1'b0;
            mem_err    = 1'b0;
            stall_PC   = 1'b0;
            stall_F_D  = 1'b0;
            stall_D_EX = 1'b0;
            stall_EX_M = 1'b0;
            flush_F_D  = 1'b0;
            flush_D_EX = 1'b0;
            flush_M_WB = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 16'd0;
        else if (stall_PC && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr_D, rs2_addr_D, rd_waddr_EX;
    logic        MemRead_EX, redirect_EX, MemRead_M, MemWrite_M;
    logic        dmem_req, dmem_ack;
    logic        stall_PC, stall_F_D, stall_D_EX, stall_EX_M;
    logic        flush_F_D, flush_D_EX, flush_M_WB;
    logic [15:0] stall_cycles;
    logic        mem_err;

    int tests = 0;
    int fails = 0;

`ifdef HAZARD_CTRL_TIMEOUT_EN
    localparam int TO_LIMIT = 15;
`else
    localparam int TO_LIMIT = -1;
`endif

    // Model state: is an access outstanding from an earlier cycle, how many
    // waiting cycles have elapsed, and the running stall count.
    bit m_pending = 1'b0;
    int m_waited  = 0;
    int m_count   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rd_waddr_EX(rd_waddr_EX), .MemRead_EX(MemRead_EX),
        .redirect_EX(redirect_EX),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .stall_PC(stall_PC), .stall_F_D(stall_F_D),
        .stall_D_EX(stall_D_EX), .stall_EX_M(stall_EX_M),
        .flush_F_D(flush_F_D), .flush_D_EX(flush_D_EX), .flush_M_WB(flush_M_WB),
        .stall_cycles(stall_cycles), .mem_err(mem_err)
    );

    // Returns {req, err, sPC, sFD, sDEX, sEXM, fFD, fDEX, fMWB}
    function automatic logic [8:0] model_out();
        bit op, lu, hold, tmo, req;
        bit s_pc, s_fd, s_dex, s_exm, f_fd, f_dex, f_mwb;
        if (rst) return 9'd0;
        op   = MemRead_M || MemWrite_M;
        lu   = MemRead_EX && rd_waddr_EX != 0 &&
               (rd_waddr_EX == rs1_addr_D || rd_waddr_EX == rs2_addr_D);
        tmo  = m_pending && !dmem_ack && (m_waited == TO_LIMIT);
        hold = !dmem_ack && !tmo && (m_pending || op);
        req  = m_pending ? !tmo : op;
        s_pc = hold || (!redirect_EX && lu);
        s_fd = s_pc;
        s_dex = hold;
        s_exm = hold;
        f_fd  = !hold && redirect_EX;
        f_dex = !hold && (redirect_EX || lu);
        f_mwb = hold || tmo;
        return {req, tmo, s_pc, s_fd, s_dex, s_exm, f_fd, f_dex, f_mwb};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [8:0] e;
        e = model_out();
        if (rst) begin
            m_pending = 1'b0;
            m_waited  = 0;
            m_count   = 0;
        end else begin
            if (e[6]) m_count = (m_count < 65535) ? m_count + 1 : 65535;
            m_waited  = (m_pending && e[4]) ? m_waited + 1 : 0;
            m_pending = e[4];
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        e = model_out();
        chk("outputs", int'({dmem_req, mem_err, stall_PC, stall_F_D, stall_D_EX,
                             stall_EX_M, flush_F_D, flush_D_EX, flush_M_WB}), int'(e));
        chk("stall_cycles", int'(stall_cycles), m_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs1_addr_D = 0; rs2_addr_D = 0; rd_waddr_EX = 0;
        MemRead_EX = 0; redirect_EX = 0; MemRead_M = 0; MemWrite_M = 0;
        dmem_ack = 0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset_req", dmem_req, 0);
        chk("reset_count", stall_cycles, 0);
        rst = 1'b0;
        tick();

        // Load-use on rs2: one bubble cycle
        MemRead_EX = 1; rd_waddr_EX = 5; rs2_addr_D = 5; rs1_addr_D = 1;
        @(negedge clk);
        chk("lu_stall_pc", stall_PC, 1);
        chk("lu_flush_dex", flush_D_EX, 1);
        chk("lu_stall_exm", stall_EX_M, 0);
        tick();
        clr();
        @(negedge clk);
        chk("lu_after", stall_PC, 0);
        tick();

        // Store waits 3 cycles for ack
        do_reset();
        MemWrite_M = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mw_stall", stall_PC, 1);
            chk("mw_req", dmem_req, 1);
            tick();
        end
        dmem_ack = 1;
        @(negedge clk);
        chk("mw_ack_stall", stall_PC, 0);
        chk("mw_ack_req", dmem_req, 1);
        chk("mw_ack_fmwb", flush_M_WB, 0);
        tick();
        clr();
        @(negedge clk);
        chk("mw_no_reissue", dmem_req, 0);
        chk("mw_count", stall_cycles, 3);
        tick();

        // Redirect beats load-use
        MemRead_EX = 1; rd_waddr_EX = 7; rs1_addr_D = 7; redirect_EX = 1;
        @(negedge clk);
        chk("rd_lu_ffd", flush_F_D, 1);
        chk("rd_lu_fdex", flush_D_EX, 1);
        chk("rd_lu_spc", stall_PC, 0);
        tick();

        // Redirect held back during memory wait
        do_reset();
        MemRead_M = 1; redirect_EX = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rw_no_flush", flush_F_D, 0);
            tick();
        end
        dmem_ack = 1;
        @(negedge clk);
        chk("rw_release_flush", flush_F_D, 1);
        chk("rw_release_spc", stall_PC, 0);
        tick();

        // Reset in the middle of a wait; late ack ignored
        clr();
        MemRead_M = 1;
        tick(); tick();
        rst = 1;
        @(negedge clk);
        chk("rst_mid_req", dmem_req, 0);
        tick();
        rst = 0; MemRead_M = 0; dmem_ack = 1;
        @(negedge clk);
        chk("rst_mid_count", stall_cycles, 0);
        chk("rst_late_ack_req", dmem_req, 0);
        chk("rst_late_ack_stall", stall_PC, 0);
        tick();

        // Ack never arrives
        do_reset();
        MemRead_M = 1;
`ifdef HAZARD_CTRL_TIMEOUT_EN
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("to_err", mem_err, (k == 17) ? 1 : 0);
            chk("to_stall", stall_PC, (k == 17) ? 0 : 1);
            tick();
        end
        MemRead_M = 0;
        @(negedge clk);
        chk("to_idle_req", dmem_req, 0);
        chk("to_idle_err", mem_err, 0);
        tick();
`else
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("noto_err", mem_err, 0);
            chk("noto_stall", stall_PC, 1);
            tick();
        end
        dmem_ack = 1;
        tick();
        clr();
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rs1_addr_D  = 5'($urandom_range(0, 3));
            rs2_addr_D  = 5'($urandom_range(0, 3));
            rd_waddr_EX = 5'($urandom_range(0, 3));
            MemRead_EX  = 1'($urandom_range(0, 1));
            redirect_EX = ($urandom_range(0, 4) == 0);
            MemRead_M   = ($urandom_range(0, 3) == 0);
            MemWrite_M  = ($urandom_range(0, 4) == 0);
            dmem_ack    = (i < 2000) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 11) == 0);
            rst         = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 0;
        clr();
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
